// File: rtl/edge_cache.sv
// -----------------------------------------------------------------------------
// edge_cache
//   Single-row cache for the adjacency matrix of the Dijkstra engine. A query
//   for (from_node, to_node) loads the whole row from_node from memory, one
//   word per read, and then serves any column combinationally. The address
//   bus is shared with the result writer, so it is released whenever no query
//   is active.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   base_address        byte address of matrix entry (0,0)
//   number_of_nodes     matrix dimension N (N <= MAX_NODES)
//   query               client wants edge data
//   from_node, to_node  row / column of the requested edge
//   mem_addr            read byte address, high-Z while query=0
//   mem_read_enable     read command (held until wait_request drops)
//   wait_request        memory stall, command not accepted while high
//   mem_read_data       returned word
//   mem_read_ready      read-data-valid strobe
//   ready               cached row matches from_node and is complete
//   edge_value          weight of (from_node, to_node), all-ones if column >= N
// -----------------------------------------------------------------------------
module edge_cache #(
  parameter int MAX_NODES   = 32,
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 32,
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   query,
  input  logic [INDEX_WIDTH-1:0] from_node,
  input  logic [INDEX_WIDTH-1:0] to_node,
  output tri   [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   mem_read_enable,
  input  logic                   mem_read_ready,
  output logic                   ready,
  output logic [VALUE_WIDTH-1:0] edge_value,
  input  logic                   wait_request
);

  localparam int ROW_AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int BYTES  = MDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_VALID
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [VALUE_WIDTH-1:0] r_row [MAX_NODES];
  logic [INDEX_WIDTH-1:0] r_cached_row;
  logic [INDEX_WIDTH-1:0] r_j;
  logic                   r_row_valid;
  logic                   r_abort;      // query dropped after a command was accepted

  logic                   w_hit;
  logic                   w_empty;
  logic                   w_last;
  logic                   w_keep;
  logic                   w_start;
  logic                   w_read_enable;
  logic                   w_ready;
  logic [MADDR_WIDTH-1:0] w_entry;
  logic [MADDR_WIDTH-1:0] w_addr;

  assign w_hit   = r_row_valid && (r_cached_row == from_node);
  assign w_empty = (number_of_nodes == '0);
  assign w_last  = ((r_j + INDEX_WIDTH'(1)) == number_of_nodes);
  // Returned data is kept only if the client is still asking for this row.
  assign w_keep  = query && !r_abort;

  // Row-major layout: entry (r,c) sits at base + (r*N + c) * bytes_per_word.
  assign w_entry = MADDR_WIDTH'(r_cached_row) * MADDR_WIDTH'(number_of_nodes)
                 + MADDR_WIDTH'(r_j);
  assign w_addr  = base_address + w_entry * MADDR_WIDTH'(BYTES);

  assign mem_addr        = query ? w_addr : {MADDR_WIDTH{1'bz}};
  assign mem_read_enable = w_read_enable;
  assign ready           = w_ready;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_read_enable = 1'b0;
    w_ready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (query) begin
          if (w_hit) begin
            w_next_state = S_VALID;
          end else begin
            w_start      = 1'b1;
            w_next_state = w_empty ? S_VALID : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // An unaccepted command is simply withdrawn when the query drops.
        if (!query) begin
          w_next_state = S_IDLE;
        end else begin
          w_read_enable = 1'b1;
          if (!wait_request) w_next_state = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        // The accepted read must complete even if the query went away.
        if (mem_read_ready) begin
          if (!w_keep)     w_next_state = S_IDLE;
          else if (w_last) w_next_state = S_VALID;
          else             w_next_state = S_ISSUE;
        end
      end
      S_VALID: begin
        if (!query) begin
          w_next_state = S_IDLE;
        end else if (r_cached_row != from_node) begin
          w_start      = 1'b1;
          w_next_state = w_empty ? S_VALID : S_ISSUE;
        end else begin
          w_ready = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cached_row <= '0;
      r_j          <= '0;
      r_row_valid  <= 1'b0;
      r_abort      <= 1'b0;
    end else if (w_start) begin
      r_cached_row <= from_node;
      r_j          <= '0;
      r_abort      <= 1'b0;
      // An empty matrix has nothing to fetch, so the row is complete at once.
      r_row_valid  <= w_empty;
    end else if (r_state == S_WAIT_DATA) begin
      if (mem_read_ready) begin
        r_abort <= 1'b0;
        if (w_keep) begin
          if (w_last) r_row_valid <= 1'b1;
          else        r_j         <= r_j + INDEX_WIDTH'(1);
        end
      end else if (!query) begin
        r_abort <= 1'b1;
      end
    end
  end

  // NOTE: the row storage has no reset; its contents are qualified by
  // r_row_valid, so clearing it would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (!reset && (r_state == S_WAIT_DATA) && mem_read_ready && w_keep)
      r_row[r_j[ROW_AW-1:0]] <= mem_read_data[VALUE_WIDTH-1:0];
  end

  always_comb begin
    edge_value = '1;
    if ((to_node < number_of_nodes) && (int'(to_node) < MAX_NODES))
      edge_value = r_row[to_node[ROW_AW-1:0]];
  end

endmodule

// File: tb/tb_edge_cache.sv
// -----------------------------------------------------------------------------
// tb_edge_cache
//   Directed bench for edge_cache. A small memory responder returns
//   0xA000_0000 | byte_address for every accepted read, one cycle after the
//   command is accepted, and can stall a chosen read with wait_request. A
//   pull-up on the shared address bus makes the released bus read as all-ones.
// -----------------------------------------------------------------------------
module tb_edge_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] base_address;
  logic [7:0]  number_of_nodes;
  logic        query;
  logic [7:0]  from_node;
  logic [7:0]  to_node;
  wire  [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        mem_read_enable;
  logic        resp_ready;
  logic        stray_ready;
  logic        ready;
  logic [31:0] edge_value;
  logic        wait_request;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_reads = 0;
  int          stall_at = -1;
  int          stall_req = 0;
  logic [31:0] rd_log [$];
  logic [31:0] held_addr;

  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;
  localparam logic [31:0] NO_EDGE  = 32'hFFFF_FFFF;

  pullup (mem_addr);

  always #5 clock = ~clock;

  edge_cache dut (
    .clock           (clock),
    .reset           (reset),
    .base_address    (base_address),
    .number_of_nodes (number_of_nodes),
    .query           (query),
    .from_node       (from_node),
    .to_node         (to_node),
    .mem_addr        (mem_addr),
    .mem_read_data   (mem_read_data),
    .mem_read_enable (mem_read_enable),
    .mem_read_ready  (resp_ready | stray_ready),
    .ready           (ready),
    .edge_value      (edge_value),
    .wait_request    (wait_request)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts negedges until ready is seen; 0 means it never rose.
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  // Returns 2 time units after the edge on which read number 'target' is accepted.
  task automatic wait_reads(input string tag, input int target);
    for (int i = 0; i < 64; i++) begin
      @(posedge clock);
      #2;
      if (n_reads >= target) break;
    end
    check({tag, "_reads_reached"}, 32'(n_reads), 32'(target));
  endtask

  // Memory responder: one outstanding read, 1-cycle response latency.
  initial begin
    resp_ready    = 1'b0;
    mem_read_data = '0;
    wait_request  = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_read_enable === 1'b1 && reset === 1'b0) begin
        if (stall_req > 0 && n_reads == stall_at) begin
          held_addr    = mem_addr;
          wait_request = 1'b1;
          repeat (stall_req) begin
            @(negedge clock);
            check("stall_enable_held", 32'(mem_read_enable), 32'd1);
            check("stall_addr_held", mem_addr, held_addr);
          end
          wait_request = 1'b0;
          stall_req    = 0;
        end
        rd_log.push_back(mem_addr);
        n_reads++;
        @(posedge clock);
        #1;
        resp_ready    = 1'b1;
        mem_read_data = 32'hA000_0000 | rd_log[$];
        @(posedge clock);
        #1;
        resp_ready    = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    query           = 1'b0;
    base_address    = 32'h0000_0100;
    number_of_nodes = 8'd4;
    from_node       = 8'd0;
    to_node         = 8'd0;
    stray_ready     = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_enable", 32'(mem_read_enable), 32'd0);
    check("rst_addr_released", mem_addr, RELEASED);
    tick();
    reset = 1'b0;

    // Cold fetch of row 2, N=4, base 0x100
    tick();
    from_node = 8'd2;
    to_node   = 8'd0;
    query     = 1'b1;
    @(negedge clock);
    check("cold_ready_low", 32'(ready), 32'd0);
    wait_ready("cold", 9);
    check("cold_reads", 32'(n_reads), 32'd4);
    check("cold_addr0", rd_log[0], 32'h0000_0120);
    check("cold_addr1", rd_log[1], 32'h0000_0124);
    check("cold_addr2", rd_log[2], 32'h0000_0128);
    check("cold_addr3", rd_log[3], 32'h0000_012C);

    // Hits on the cached row
    tick(); to_node = 8'd0; @(negedge clock);
    check("hit_c0", edge_value, 32'hA000_0120);
    tick(); to_node = 8'd1; @(negedge clock);
    check("hit_c1", edge_value, 32'hA000_0124);
    tick(); to_node = 8'd2; @(negedge clock);
    check("hit_c2", edge_value, 32'hA000_0128);
    tick(); to_node = 8'd3; @(negedge clock);
    check("hit_c3", edge_value, 32'hA000_012C);
    check("hit_ready", 32'(ready), 32'd1);
    check("hit_no_reads", 32'(n_reads), 32'd4);

    // Out-of-range columns
    tick(); to_node = 8'd4; @(negedge clock);
    check("oor_col_n", edge_value, NO_EDGE);
    tick(); to_node = 8'd200; @(negedge clock);
    check("oor_col_200", edge_value, NO_EDGE);

    // Row switch to row 1
    tick();
    from_node = 8'd1;
    to_node   = 8'd3;
    @(negedge clock);
    check("switch_ready_low", 32'(ready), 32'd0);
    wait_ready("switch", 9);
    check("switch_reads", 32'(n_reads), 32'd8);
    check("switch_addr0", rd_log[4], 32'h0000_0110);
    check("switch_addr1", rd_log[5], 32'h0000_0114);
    check("switch_addr2", rd_log[6], 32'h0000_0118);
    check("switch_addr3", rd_log[7], 32'h0000_011C);
    check("switch_value", edge_value, 32'hA000_011C);

    // Row 3 with a 3-cycle stall on its second word
    tick();
    stall_at  = 9;
    stall_req = 3;
    from_node = 8'd3;
    to_node   = 8'd1;
    @(negedge clock);
    check("stall_ready_low", 32'(ready), 32'd0);
    wait_ready("stall", 12);
    check("stall_reads", 32'(n_reads), 32'd12);
    check("stall_addr0", rd_log[8], 32'h0000_0130);
    check("stall_addr1", rd_log[9], 32'h0000_0134);
    check("stall_addr2", rd_log[10], 32'h0000_0138);
    check("stall_addr3", rd_log[11], 32'h0000_013C);
    check("stall_value1", edge_value, 32'hA000_0134);
    tick(); to_node = 8'd3; @(negedge clock);
    check("stall_value3", edge_value, 32'hA000_013C);

    // Abort: drop the query after the second command of row 0 is accepted
    tick();
    query = 1'b0;
    @(negedge clock);
    check("idle_ready_low", 32'(ready), 32'd0);
    tick();
    from_node = 8'd0;
    to_node   = 8'd2;
    query     = 1'b1;
    wait_reads("abort", 14);
    query = 1'b0;
    @(negedge clock);
    check("abort_enable", 32'(mem_read_enable), 32'd0);
    check("abort_addr_released", mem_addr, RELEASED);
    repeat (3) tick();
    @(negedge clock);
    check("abort_no_more_reads", 32'(n_reads), 32'd14);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_addr0", rd_log[12], 32'h0000_0100);
    check("abort_addr1", rd_log[13], 32'h0000_0104);

    // Re-query the same row: the whole row is fetched again
    tick();
    query = 1'b1;
    @(negedge clock);
    check("refetch_ready_low", 32'(ready), 32'd0);
    wait_ready("refetch", 9);
    check("refetch_reads", 32'(n_reads), 32'd18);
    check("refetch_addr0", rd_log[14], 32'h0000_0100);
    check("refetch_addr3", rd_log[17], 32'h0000_010C);
    check("refetch_value", edge_value, 32'hA000_0108);

    // Requery from IDLE of a still-valid row: no reads, ready next cycle
    tick();
    query = 1'b0;
    tick();
    query = 1'b1;
    @(negedge clock);
    check("reuse_ready_low", 32'(ready), 32'd0);
    @(negedge clock);
    check("reuse_ready_high", 32'(ready), 32'd1);
    check("reuse_no_reads", 32'(n_reads), 32'd18);

    // Reset in WAIT_DATA; the response arrives on the reset edge
    tick();
    from_node = 8'd1;
    wait_reads("rstmid", 19);
    reset = 1'b1;
    query = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_enable", 32'(mem_read_enable), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd0);
    tick();
    stray_ready = 1'b1;
    tick();
    stray_ready = 1'b0;
    @(negedge clock);
    check("stray_enable", 32'(mem_read_enable), 32'd0);
    check("stray_ready", 32'(ready), 32'd0);
    check("stray_addr_released", mem_addr, RELEASED);
    tick();
    from_node = 8'd0;
    to_node   = 8'd2;
    query     = 1'b1;
    wait_ready("post_reset", 10);
    check("post_reset_reads", 32'(n_reads), 32'd23);
    check("post_reset_value", edge_value, 32'hA000_0108);

    // N=0: valid immediately, no reads, every column out of range
    tick();
    query = 1'b0;
    tick();
    number_of_nodes = 8'd0;
    from_node       = 8'd5;
    to_node         = 8'd0;
    query           = 1'b1;
    @(negedge clock);
    check("n0_ready_low", 32'(ready), 32'd0);
    @(negedge clock);
    check("n0_ready_high", 32'(ready), 32'd1);
    check("n0_value", edge_value, NO_EDGE);
    check("n0_no_reads", 32'(n_reads), 32'd23);

    tick();
    query = 1'b0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_cache.md
Name: edge_cache

Overview:
- Row cache for the adjacency matrix used by the hardware Dijkstra engine.
- On a query for edge (from_node, to_node) it fetches the whole row `from_node` from external memory into local registers, one word at a time, over an Avalon-style read port.
- Once the row is loaded it serves any `to_node` in that row combinationally.
- The memory address bus is shared with the result writer, so this block releases it (high-Z) whenever no query is active.

Parameters:
- MAX_NODES, 32: maximum graph size; row storage depth.
- INDEX_WIDTH, 8: width of node indices.
- VALUE_WIDTH, 32: width of an edge weight.
- MADDR_WIDTH, 32: memory byte-address width.
- MDATA_WIDTH, 32: memory data width; one matrix entry per word.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- base_address  in  MADDR_WIDTH  byte address of matrix entry (0,0).
- number_of_nodes  in  INDEX_WIDTH  N, matrix dimension (N <= MAX_NODES).
- query  in  1  high while the client wants edge data.
- from_node  in  INDEX_WIDTH  row index.
- to_node  in  INDEX_WIDTH  column index.
- mem_addr  out  MADDR_WIDTH  read address; high-Z when query=0.
- mem_read_data  in  MDATA_WIDTH  returned word.
- mem_read_enable  out  1  read command.
- mem_read_ready  in  1  read-data-valid strobe.
- ready  out  1  cached row matches from_node and is complete.
- edge_value  out  VALUE_WIDTH  weight of (from_node, to_node).
- wait_request  in  1  memory stall; command not accepted while high.

Behaviour:
- **Matrix layout:** row-major. Entry (r,c) is at base_address + (r*N + c)*(MDATA_WIDTH/8). edge_value is taken from the low VALUE_WIDTH bits of the word.
- **Registers:** row[0..MAX_NODES-1], cached_row (INDEX_WIDTH), row_valid, fetch column j, state.
- **Reset (synchronous):**
  - state=IDLE, row_valid=0, mem_read_enable=0, ready=0, j=0.
  - Row contents are don't-care.
  - A reset mid-fetch aborts immediately; any late mem_read_ready is ignored.
- **State IDLE:**
  - mem_read_enable=0.
  - If query=1 and (row_valid=0 or cached_row!=from_node): latch cached_row=from_node, set j=0, clear row_valid, go to ISSUE.
  - If query=1 and the row is already valid and matches: go to VALID.
- **State ISSUE:**
  - Drive mem_read_enable=1 and mem_addr = address of (cached_row, j).
  - Hold both stable while wait_request=1.
  - On the first cycle with wait_request=0 the command is accepted. Next cycle: mem_read_enable=0, go to WAIT_DATA.
- **State WAIT_DATA:**
  - On mem_read_ready=1, write row[j] <= mem_read_data[VALUE_WIDTH-1:0].
  - If j==N-1: set row_valid=1 and go to VALID.
  - Otherwise: j<=j+1 and go to ISSUE.
- **Outstanding reads:** at most one outstanding read at any time.
- **State VALID:**
  - ready = query & (cached_row==from_node), combinational.
  - If query=1 and from_node differs from cached_row: start a new fetch as from IDLE, with ready=0 in that same cycle.
  - If query=0: go to IDLE. Row stays valid for reuse.
- **Query drops mid-fetch:**
  - If the command is not yet accepted, drop it at once.
  - If a read was accepted, wait in WAIT_DATA for its mem_read_ready, discard the data, then go to IDLE.
  - In both cases row_valid=0.
- **edge_value:** row[to_node], combinational. It is all-ones when to_node >= N. Valid only while ready=1.
- **N=0:** a query sets row_valid immediately with no memory reads; ready rises the next cycle.
- **Fetch latency:** per word = 1 + wait_request cycles + response latency. ready rises the cycle after the last mem_read_ready.
- **Bus release:** mem_addr is driven only while query=1. mem_read_enable is never asserted while query=0.

Test Plan:
- **Cold row fetch:** N=4, base=0x100, query row 2 with wait_request=0 and 1-cycle response. Expect reads at 0x120, 0x124, 0x128, 0x12C. ready rises after the 4th data beat. edge_value for to_node=0..3 equals the memory contents.
- **Hit and row switch:** with row 2 cached, step to_node 0..3. Expect ready stays high and no memory reads. Then change from_node to 1: ready=0 in the same cycle, reads at 0x110–0x11C, then ready=1.
- **Stall:** hold wait_request=1 for 3 cycles on the second word. Expect mem_read_enable and mem_addr stable for those 3 cycles, no duplicate reads, and correct data afterwards.
- **Abort:** drop query after the 2nd command is accepted. Expect the block waits for one mem_read_ready, then IDLE with mem_addr=Z. A re-query of the same row refetches all N words.
- **Reset mid-fetch:** assert reset during WAIT_DATA. Next cycle mem_read_enable=0 and ready=0. A stray mem_read_ready does not change state.
- **Out-of-range column:** query to_node=N with row valid. Expect edge_value=all-ones.
